morse_key_classifier: RTL
=========================

Name: morse_key_classifier

Overview:
- Front end of the Morse receive path, directly upstream of the symbol decoder.
- Samples a raw telegraph key, measures mark and space durations in clock cycles, and classifies each into DOT, DASH, INTERCHAR or INTERWORD.
- Buffers the classified symbols in a small FIFO and presents the head symbol to the decoder using the writing/read_out handshake.

Parameters:
- TICKS_PER_UNIT, 50000, clock cycles per Morse time unit (must be ≥ 2).
- FIFO_DEPTH, 8, symbol FIFO entries (power of two, ≥ 2).
- DEBOUNCE_CYCLES, 1000, cycles the key must be stable to be accepted (used only with MORSE_DEBOUNCE_EN).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- key  in  1  raw asynchronous key input, 1 = pressed
- read_out  in  1  decoder acknowledge; one-cycle pulse, pops the FIFO head
- writing  out  1  head symbol valid
- dot  out  1  head is DOT
- dash  out  1  head is DASH
- interchar  out  1  head is INTERCHAR
- interword  out  1  head is INTERWORD
- overflow  out  1  sticky flag: a symbol was dropped because the FIFO was full

Behaviour:
- Interface: reset is reset, synchronous, active-high; clock is clk.
- Reset values: all outputs 0, FIFO empty, FSM in IDLE, counters 0.
- Key synchronisation:
  - key passes through a 2-flop synchroniser to produce key_s.
  - Latency from key to key_s is 2 cycles.
- Output decode:
  - writing = !empty && !read_out. This masks the head during the pop cycle, so the registered read_out of the decoder can never double-consume a symbol.
  - The four symbol outputs are one-hot decode of the head when writing = 1, and all 0 otherwise.
- FSM states: IDLE, MARK, SPACE.
  - IDLE:
    - key_s = 1 → MARK, with press_cnt = 1.
    - Space time is not measured here, so no gap symbols are produced after reset or after an INTERWORD.
  - MARK:
    - key_s = 1 → press_cnt increments, saturating at 2*TICKS_PER_UNIT.
    - key_s = 0 → enqueue DOT if press_cnt < 2*TICKS_PER_UNIT, else DASH; then go to SPACE with gap_cnt = 1.
  - SPACE:
    - key_s = 1 → MARK, with press_cnt = 1.
    - Otherwise gap_cnt increments.
    - When gap_cnt reaches 3*TICKS_PER_UNIT, enqueue INTERCHAR (once).
    - When gap_cnt reaches 7*TICKS_PER_UNIT, enqueue INTERWORD and go to IDLE.
    - A gap shorter than 3 units produces no symbol (intra-character space).
- Symbol timing:
  - A symbol is enqueued on the edge where the transition is decided.
  - writing rises the following cycle if the FIFO was empty.
- Counter width: $clog2(7*TICKS_PER_UNIT+1). Counters never wrap.
- FIFO:
  - Circular buffer with read/write pointers and an occupancy count.
  - Push and pop in the same cycle are both honoured and the count is unchanged, including when the FIFO is full.
  - A push while full without a same-cycle pop drops the new symbol and sets overflow.
  - read_out while empty is ignored.
- Reset mid-operation:
  - FIFO is cleared, FSM returns to IDLE, overflow is cleared.
  - A key held across reset is treated as a fresh press once reset deasserts.

Optional Feature:
- Macro: MORSE_DEBOUNCE_EN.
- Defined:
  - key_s feeds a stability counter.
  - The filtered key changes only after key_s differs from the filtered value for DEBOUNCE_CYCLES consecutive cycles.
  - All durations are measured on the filtered key, which adds DEBOUNCE_CYCLES of latency.
- Undefined: the FSM consumes key_s directly, with no filter logic.

Decomposition:
- Package morse_pkg holds:
  - 2-bit symbol encoding: SYM_DOT = 0, SYM_DASH = 1, SYM_ICHAR = 2, SYM_IWORD = 3.
  - FSM state enum.
  - Threshold multipliers: DASH_UNITS = 2, ICHAR_UNITS = 3, IWORD_UNITS = 7.
- Sub-module morse_sym_fifo: parameterised 2-bit-wide synchronous FIFO with push, pop, full, empty, head and overflow.

Test Plan (TICKS_PER_UNIT = 4, FIFO_DEPTH = 4, debounce off unless stated):
- Press key 4 cycles, then release for 40 cycles, read_out acking each symbol → decoder sees DOT, INTERCHAR (12 gap cycles after release), INTERWORD (28 gap cycles after release); FSM ends in IDLE.
- Presses of 12, 8, 7 and 1 cycles, each separated by 6-cycle gaps → DASH, DASH, DOT, DOT, with no INTERCHAR between them.
- read_out held low while 5 symbols are generated → 4 symbols stored, overflow = 1, head remains the first DOT, 5th symbol lost.
- FIFO holds 2 symbols; pulse read_out for 1 cycle → writing = 0 in that cycle, second symbol presented on the next cycle with writing = 1; a second pulse empties the FIFO.
- Assert reset for 1 cycle in the middle of a 10-cycle press → all outputs 0 and FIFO empty; key still held after reset → classified as a new press measured from reset deassertion.
- With MORSE_DEBOUNCE_EN and DEBOUNCE_CYCLES = 3: a 2-cycle glitch on key → no symbol; a 20-cycle press → single DASH.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared types and thresholds for the Morse key classifier.
package morse_pkg;

  typedef enum logic [1:0] {
    SYM_DOT   = 2'd0,
    SYM_DASH  = 2'd1,
    SYM_ICHAR = 2'd2,
    SYM_IWORD = 2'd3
  } sym_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MARK,
    ST_SPACE
  } state_t;

  localparam int DASH_UNITS  = 2;
  localparam int ICHAR_UNITS = 3;
  localparam int IWORD_UNITS = 7;

endpackage

// File: rtl/morse_sym_fifo.sv
// Small circular FIFO of 2-bit Morse symbols with a sticky overflow flag.
module morse_sym_fifo
  import morse_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  sym_t push_sym,
  input  logic pop,
  output logic full,
  output logic empty,
  output sym_t head,
  output logic overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  sym_t          mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_sym;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !do_push) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/morse_key_classifier.sv
// Classifies key mark/space durations into Morse symbols and queues them for the decoder.
// Optional key debounce filter enabled by defining MORSE_DEBOUNCE_EN.
module morse_key_classifier
  import morse_pkg::*;
#(
  parameter int TICKS_PER_UNIT  = 50000,
  parameter int FIFO_DEPTH      = 8,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  input  logic read_out,
  output logic writing,
  output logic dot,
  output logic dash,
  output logic interchar,
  output logic interword,
  output logic overflow
);

  localparam int CNT_W = $clog2(IWORD_UNITS * TICKS_PER_UNIT + 1);
  localparam logic [CNT_W-1:0] DASH_MAX = CNT_W'(DASH_UNITS * TICKS_PER_UNIT);
  localparam logic [CNT_W-1:0] ICHAR_AT = CNT_W'(ICHAR_UNITS * TICKS_PER_UNIT);
  localparam logic [CNT_W-1:0] IWORD_AT = CNT_W'(IWORD_UNITS * TICKS_PER_UNIT);

  logic             key_m;
  logic             key_s;
  logic             key_q;
  state_t           state, state_n;
  logic [CNT_W-1:0] press_cnt, press_n;
  logic [CNT_W-1:0] gap_cnt, gap_n;
  logic             push;
  sym_t             push_sym;
  logic             empty;
  logic             full;
  sym_t             head;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_m <= 1'b0;
      key_s <= 1'b0;
    end else begin
      key_m <= key;
      key_s <= key_m;
    end
  end

`ifdef MORSE_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic            key_f;
  logic [DB_W-1:0] db_cnt;

  // The filtered key follows key_s only after it has disagreed for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_f  <= 1'b0;
      db_cnt <= '0;
    end else if (key_s != key_f) begin
      if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        key_f  <= key_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  assign key_q = key_f;
`else
  assign key_q = key_s;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      press_cnt <= '0;
      gap_cnt   <= '0;
    end else begin
      state     <= state_n;
      press_cnt <= press_n;
      gap_cnt   <= gap_n;
    end
  end

  // Gap thresholds fire on the edge the count reaches them, so each gap symbol is emitted once.
  always_comb begin
    state_n  = state;
    press_n  = press_cnt;
    gap_n    = gap_cnt;
    push     = 1'b0;
    push_sym = SYM_DOT;
    case (state)
      ST_IDLE: begin
        if (key_q) begin
          state_n = ST_MARK;
          press_n = CNT_W'(1);
        end
      end
      ST_MARK: begin
        if (key_q) begin
          if (press_cnt < DASH_MAX) press_n = press_cnt + 1'b1;
        end else begin
          push     = 1'b1;
          push_sym = (press_cnt < DASH_MAX) ? SYM_DOT : SYM_DASH;
          state_n  = ST_SPACE;
          gap_n    = CNT_W'(1);
        end
      end
      ST_SPACE: begin
        if (key_q) begin
          state_n = ST_MARK;
          press_n = CNT_W'(1);
        end else begin
          gap_n = gap_cnt + 1'b1;
          if (gap_n == ICHAR_AT) begin
            push     = 1'b1;
            push_sym = SYM_ICHAR;
          end else if (gap_n == IWORD_AT) begin
            push     = 1'b1;
            push_sym = SYM_IWORD;
            state_n  = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  morse_sym_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .push_sym(push_sym),
    .pop     (read_out),
    .full    (full),
    .empty   (empty),
    .head    (head),
    .overflow(overflow)
  );

  // Hiding the head during the pop cycle keeps a registered acknowledge from consuming twice.
  assign writing   = !empty && !read_out;
  assign dot       = writing && (head == SYM_DOT);
  assign dash      = writing && (head == SYM_DASH);
  assign interchar = writing && (head == SYM_ICHAR);
  assign interword = writing && (head == SYM_IWORD);

endmodule
